// File: rtl/lsu_bus_adapter.sv
// Load/store adapter from core memory decode to a word-aligned valid/ready data bus.
// MISALIGNED_SPLIT_EN: split word-crossing accesses into two beats; otherwise they raise misaligned_err.
module lsu_bus_adapter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        mask_type,
  input  logic              ext_type,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              misaligned_err,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t      state;
  logic [1:0]  off_q, mt_q;
  logic        ext_q, we_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q, lo_q;
  logic [3:0]  size_mask;
  logic [7:0]  be8;
  logic [63:0] wd64;
  logic        split, split_err;

  always_comb begin
    case (mask_type)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be8   = {4'b0000, size_mask} << req_addr[1:0];
    wd64  = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    split = |be8[7:4];
  end

`ifdef MISALIGNED_SPLIT_EN
  assign split_err = 1'b0;
`else
  assign split_err = split;
`endif

  assign stall = req_valid & (state != DONE);

  // Shift the two-beat window down to the access offset, then size and extend.
  function automatic logic [31:0] extract(input logic [63:0] r64, input logic [1:0] off,
                                          input logic [1:0] mt, input logic ext);
    logic [31:0] s;
    s = 32'(r64 >> {off, 3'b000});
    case (mt)
      2'b00:   extract = {{24{~ext & s[7]}}, s[7:0]};
      2'b01:   extract = {{16{~ext & s[15]}}, s[15:0]};
      default: extract = s;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      off_q          <= '0;
      mt_q           <= '0;
      ext_q          <= 1'b0;
      we_q           <= 1'b0;
      be_hi_q        <= '0;
      wd_hi_q        <= '0;
      lo_q           <= '0;
      rdata          <= '0;
      misaligned_err <= 1'b0;
      bus_valid      <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_be         <= '0;
      bus_wdata      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          off_q   <= req_addr[1:0];
          mt_q    <= mask_type;
          ext_q   <= ext_type;
          we_q    <= req_we;
          be_hi_q <= be8[7:4];
          wd_hi_q <= wd64[63:32];
          if (split_err) begin
            misaligned_err <= 1'b1;
            state          <= DONE;
          end else begin
            bus_valid <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            bus_be    <= be8[3:0];
            bus_wdata <= wd64[31:0];
            state     <= BEAT0;
          end
        end
        BEAT0: if (bus_ready) begin
          lo_q <= bus_rdata;
          if (|be_hi_q) begin
            bus_addr  <= bus_addr + ADDR_W'(4);
            bus_be    <= be_hi_q;
            bus_wdata <= wd_hi_q;
            state     <= BEAT1;
          end else begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_wdata <= '0;
            if (!we_q) rdata <= extract({32'b0, bus_rdata}, off_q, mt_q, ext_q);
            state     <= DONE;
          end
        end
        BEAT1: if (bus_ready) begin
          bus_valid <= 1'b0;
          bus_we    <= 1'b0;
          bus_be    <= '0;
          bus_wdata <= '0;
          if (!we_q) rdata <= extract({bus_rdata, lo_q}, off_q, mt_q, ext_q);
          state     <= DONE;
        end
        default: begin
          misaligned_err <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Data-side counterpart of the control path: consumes memory-request decode (write enable, mask_type, ext_type) plus ALU-computed address and store data.
- Drives a 32-bit word-aligned valid/ready data bus with byte enables; returns aligned, sign- or zero-extended load data to the result mux.
- Stalls the single-cycle core while a bus access is in flight; splits misaligned accesses into two bus beats.

Parameters:
- ADDR_W, 32, byte-address width of core request and bus

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  current instruction is load/store
- req_we  in  1  1 = store (MemWrite), 0 = load
- req_addr  in  ADDR_W  byte address from ALU
- req_wdata  in  32  store data (rs2)
- mask_type  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ext_type  in  1  0 = sign-extend, 1 = zero-extend (loads only)
- stall  out  1  hold PC/regfile write
- rdata  out  32  extended load result, valid when stall=0 after a load
- misaligned_err  out  1  one-cycle pulse, see Optional Feature
- bus_valid  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word-aligned address, bits[1:0]=00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_ready  in  1  bus accepts/completes beat
- bus_rdata  in  32  read data, valid with bus_ready on load beats

Behaviour:
- Reset: state IDLE; bus_valid=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, misaligned_err=0. Asserting rst mid-transfer drops bus_valid immediately; the beat is abandoned.
- stall = req_valid & (state != DONE), combinational.
- Size bytes: 1/2/4 from mask_type; off = req_addr[1:0].
- Lanes: 8-bit be8 = size_mask << off; 64-bit wd64 = req_wdata << (8*off). Beat0 uses be8[3:0]/wd64[31:0]; beat1 uses be8[7:4]/wd64[63:32]. split = |be8[7:4].
- FSM:
  - IDLE: req_valid -> capture request into registers, go BEAT0. All bus outputs registered; bus_valid rises first cycle after acceptance (minimum load/store latency 3 cycles: IDLE, BEAT0 with ready, DONE).
  - BEAT0: bus_valid=1, bus_addr = {addr[ADDR_W-1:2],00}. Outputs hold stable while bus_ready=0. On bus_ready: latch bus_rdata into lo; -> BEAT1 if split else DONE.
  - BEAT1: bus_addr = beat0 address + 4, wraps modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000). On bus_ready: latch hi -> DONE.
  - DONE: bus_valid=0, stall=0 for exactly one cycle; core advances. -> IDLE.
- Load data: r64 = {hi,lo} >> (8*off); take low size bytes; ext_type=0 replicates MSB of that field, 1 zero-fills. rdata updated on entry to DONE, held until next load completes.
- Store beats: rdata unchanged.
- bus_be never zero on a valid beat; beat with bus_valid=0 has bus_be=0.
- req_valid deasserted while busy (illegal for core): FSM completes the captured access anyway.

Optional Feature:
- MISALIGNED_SPLIT_EN defined: behaviour above; misaligned_err tied 0.
- Undefined: when split would be 1, IDLE goes directly to DONE without any bus beat, misaligned_err=1 during DONE, rdata unchanged, no memory write occurs. Accesses with split=0 (including byte at any offset, half at off 0..2) behave as above.

Test Plan:
- LW addr 0x100, bus_rdata 0xDEADBEEF, ready 1st cycle -> one beat addr 0x100 be 1111; rdata 0xDEADBEEF; stall high exactly 2 cycles.
- LB addr 0x103 ext 0, bus_rdata 0x80112233 -> be 1000; rdata 0xFFFFFF80; same with LBU ext 1 -> 0x00000080.
- SH addr 0x202 wdata 0x0000ABCD -> be 1100, bus_wdata 0xABCD0000, bus_we=1; rdata unchanged.
- bus_ready held low 5 cycles during BEAT0 -> bus_addr/be/wdata stable all 5 cycles, stall high throughout, completes on 6th.
- With MISALIGNED_SPLIT_EN: SW addr 0xFFFFFFFE wdata 0x11223344 -> beat0 addr 0xFFFFFFFC be 1100 wdata 0x33440000; beat1 addr 0x00000000 be 0011 wdata 0x00001122. Without: no bus_valid, misaligned_err 1-cycle pulse.
- Assert rst during BEAT1 -> bus_valid 0 same cycle, stall drops, all outputs reset values; next LW completes normally.
